// File: rtl/scfifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Read modes and the width of the word-count output.
package scfifo_pkg;

    localparam int NORMAL    = 0;
    localparam int SHOWAHEAD = 1;

    // usedw must represent 0 .. 2**awidth inclusive.
    function automatic int usedw_width(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/scfifo_ram.sv
// Simple dual-port storage for scfifo: one write port, one registered read port, no reset.
module scfifo_ram #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 10
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [2**AWIDTH];
    logic [DWIDTH-1:0] r_rd_data;

    // Read data holds its value until the next read enable.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/scfifo.sv
// Single-clock FIFO: pointers, word count, registered flags and optional show-ahead prefetch.
// Storage lives in scfifo_ram; its registered read port doubles as the show-ahead head register.
module scfifo
    import scfifo_pkg::*;
#(
    parameter int DWIDTH       = 64,
    parameter int AWIDTH       = 10,
    parameter int SHOWAHEAD    = 0,
    parameter int ALMOST_FULL  = 2**AWIDTH - 4,
    parameter int ALMOST_EMPTY = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DWIDTH-1:0]             data_i,
    input  logic                          wrreq_i,
    input  logic                          rdreq_i,
    output logic [DWIDTH-1:0]             q_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [usedw_width(AWIDTH)-1:0] usedw_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o
);

    localparam int             UW      = usedw_width(AWIDTH);
    localparam logic [UW-1:0]  DEPTH_W = UW'(2**AWIDTH);
    localparam logic [UW-1:0]  AF_W    = UW'(ALMOST_FULL);
    localparam logic [UW-1:0]  AE_W    = UW'(ALMOST_EMPTY);
    localparam bit             IS_SA   = (SHOWAHEAD != NORMAL);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [UW-1:0]     r_usedw;
    logic              r_empty;
    logic              r_full;
    logic              r_af;
    logic              r_ae;
    logic              r_head_valid;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ram_rd;
    logic              w_head_valid_d;
    logic              w_empty_d;
    logic [UW-1:0]     w_mem_cnt;
    logic [UW-1:0]     w_usedw_d;
    logic [DWIDTH-1:0] w_ram_q;

    assign w_wr_acc  = wrreq_i && !r_full;
    assign w_rd_acc  = rdreq_i && !r_empty;
    // Words still in the RAM array, excluding the one parked on the read port.
    assign w_mem_cnt = r_usedw - UW'(r_head_valid);

    always_comb begin
        w_ram_rd       = w_rd_acc;
        w_head_valid_d = r_head_valid | w_rd_acc;
        if (IS_SA) begin
            w_ram_rd       = (w_mem_cnt != '0) && (!r_head_valid || w_rd_acc);
            w_head_valid_d = w_ram_rd || (r_head_valid && !w_rd_acc);
        end
    end

    always_comb begin
        w_usedw_d = r_usedw;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_usedw_d = r_usedw + UW'(1);
            2'b01:   w_usedw_d = r_usedw - UW'(1);
            default: w_usedw_d = r_usedw;
        endcase
    end

    assign w_empty_d = IS_SA ? !w_head_valid_d : (w_usedw_d == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_usedw      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_af         <= 1'b0;
            r_ae         <= 1'b1;
            r_head_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
            end
            r_usedw      <= w_usedw_d;
            r_empty      <= w_empty_d;
            r_full       <= (w_usedw_d == DEPTH_W);
            r_af         <= (w_usedw_d >= AF_W);
            r_ae         <= (w_usedw_d < AE_W);
            r_head_valid <= w_head_valid_d;
        end
    end

    scfifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .i_clk     (clk_i),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_i),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    // The RAM is not reset, so mask its output until it holds a word read since reset.
    assign q_o            = r_head_valid ? w_ram_q : '0;
    assign empty_o        = r_empty;
    assign full_o         = r_full;
    assign usedw_o        = r_usedw;
    assign almost_full_o  = r_af;
    assign almost_empty_o = r_ae;

endmodule

// File: tb/tb_scfifo.sv
// Self-checking bench for scfifo: a normal-mode and a show-ahead instance driven in lockstep,
// each compared against a queue-based reference model.
module tb_scfifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       wrreq = 1'b0;
    logic       rdreq = 1'b0;

    logic [7:0] n_q, s_q;
    logic       n_empty, n_full, n_af, n_ae;
    logic       s_empty, s_full, s_af, s_ae;
    logic [2:0] n_usedw, s_usedw;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scfifo #(
        .DWIDTH       (8),
        .AWIDTH       (2),
        .SHOWAHEAD    (0),
        .ALMOST_FULL  (3),
        .ALMOST_EMPTY (1)
    ) u_norm (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_i         (din),
        .wrreq_i        (wrreq),
        .rdreq_i        (rdreq),
        .q_o            (n_q),
        .empty_o        (n_empty),
        .full_o         (n_full),
        .usedw_o        (n_usedw),
        .almost_full_o  (n_af),
        .almost_empty_o (n_ae)
    );

    scfifo #(
        .DWIDTH       (8),
        .AWIDTH       (2),
        .SHOWAHEAD    (1),
        .ALMOST_FULL  (3),
        .ALMOST_EMPTY (1)
    ) u_sa (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_i         (din),
        .wrreq_i        (wrreq),
        .rdreq_i        (rdreq),
        .q_o            (s_q),
        .empty_o        (s_empty),
        .full_o         (s_full),
        .usedw_o        (s_usedw),
        .almost_full_o  (s_af),
        .almost_empty_o (s_ae)
    );

    // Reference model: plain queues. A show-ahead word becomes presentable once it has
    // sat in storage across at least one clock edge after the edge that wrote it.
    typedef struct {
        logic [7:0] d;
        int         e;
    } ent_t;

    logic [7:0] nq[$];
    logic [7:0] n_exp_q = '0;
    ent_t       sq[$];
    bit         s_show = 1'b0;
    int         ecnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        nq.delete();
        sq.delete();
        n_exp_q = '0;
        s_show  = 1'b0;
    endtask

    task automatic model_update(input logic w, input logic r, input logic [7:0] d);
        bit   acc_w;
        bit   acc_r;
        ent_t tmp;
        ecnt++;
        acc_w = w && (nq.size() < 4);
        acc_r = r && (nq.size() > 0);
        if (acc_r) n_exp_q = nq.pop_front();
        if (acc_w) nq.push_back(d);
        acc_w = w && (sq.size() < 4);
        acc_r = r && s_show;
        if (acc_r) begin
            tmp    = sq.pop_front();
            s_show = 1'b0;
        end
        if (!s_show && (sq.size() > 0) && (sq[0].e < ecnt)) s_show = 1'b1;
        if (acc_w) begin
            tmp.d = d;
            tmp.e = ecnt;
            sq.push_back(tmp);
        end
    endtask

    task automatic check_all();
        int n;
        int s;
        n = nq.size();
        s = sq.size();
        chk("n_usedw", 32'(n_usedw), 32'(n));
        chk("n_empty", 32'(n_empty), 32'(n == 0));
        chk("n_full",  32'(n_full),  32'(n == 4));
        chk("n_af",    32'(n_af),    32'(n >= 3));
        chk("n_ae",    32'(n_ae),    32'(n < 1));
        chk("n_q",     32'(n_q),     32'(n_exp_q));
        chk("s_usedw", 32'(s_usedw), 32'(s));
        chk("s_empty", 32'(s_empty), 32'(!s_show));
        chk("s_full",  32'(s_full),  32'(s == 4));
        chk("s_af",    32'(s_af),    32'(s >= 3));
        chk("s_ae",    32'(s_ae),    32'(s < 1));
        chk("s_q",     32'(s_q),     s_show ? 32'(sq[0].d) : 32'h0);
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wrreq = w;
        rdreq = r;
        din   = d;
        @(posedge clk);
        #1;
        model_update(w, r, d);
        check_all();
        wrreq = 1'b0;
        rdreq = 1'b0;
    endtask

    initial begin
        logic [7:0] b_in;
        logic [7:0] b_out;

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        chk("rst_n_empty", 32'(n_empty), 32'h1);
        chk("rst_s_ae",    32'(s_ae),    32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, drop a fifth write, then drain in order
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 8'h44);
        chk("fill_full",  32'(n_full),  32'h1);
        chk("fill_usedw", 32'(n_usedw), 32'h4);
        chk("fill_af",    32'(n_af),    32'h1);
        step(1'b1, 1'b0, 8'h55);
        chk("drop_usedw", 32'(n_usedw), 32'h4);
        step(1'b0, 1'b1, 8'h00);
        chk("rd0", 32'(n_q), 32'h11);
        step(1'b0, 1'b1, 8'h00);
        chk("rd1", 32'(n_q), 32'h22);
        step(1'b0, 1'b1, 8'h00);
        chk("rd2", 32'(n_q), 32'h33);
        step(1'b0, 1'b1, 8'h00);
        chk("rd3", 32'(n_q), 32'h44);
        chk("drain_empty", 32'(n_empty), 32'h1);

        // Simultaneous requests at the empty and full boundaries
        step(1'b1, 1'b1, 8'hA5);
        chk("sim_empty_usedw", 32'(n_usedw), 32'h1);
        chk("sim_empty_q",     32'(n_q),     32'h44);
        step(1'b1, 1'b0, 8'hB1);
        step(1'b1, 1'b0, 8'hB2);
        step(1'b1, 1'b0, 8'hB3);
        chk("sim_full_pre", 32'(n_full), 32'h1);
        step(1'b1, 1'b1, 8'hEE);
        chk("sim_full_usedw", 32'(n_usedw), 32'h3);
        chk("sim_full_flag",  32'(n_full),  32'h0);
        chk("sim_full_q",     32'(n_q),     32'hA5);
        repeat (4) step(1'b0, 1'b1, 8'h00);
        chk("sim_drain_q", 32'(n_q), 32'hB3);

        // Pointer wrap: 6 rounds of 3 writes then 3 reads
        b_in  = 8'h80;
        b_out = 8'h80;
        for (int rnd = 0; rnd < 6; rnd++) begin
            for (int k = 0; k < 3; k++) begin
                step(1'b1, 1'b0, b_in);
                b_in++;
                chk("wrap_usedw_max", 32'(n_usedw <= 3), 32'h1);
            end
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b1, 8'h00);
                chk("wrap_q", 32'(n_q), 32'(b_out));
                b_out++;
            end
        end

        // Show-ahead prefetch latency
        step(1'b1, 1'b0, 8'h5A);
        chk("sa_empty_1", 32'(s_empty), 32'h1);
        step(1'b0, 1'b0, 8'h00);
        chk("sa_empty_2", 32'(s_empty), 32'h0);
        chk("sa_q",       32'(s_q),     32'h5A);
        step(1'b0, 1'b1, 8'h00);
        chk("sa_empty_3", 32'(s_empty), 32'h1);

        // Asynchronous reset mid-operation
        step(1'b1, 1'b0, 8'h61);
        step(1'b1, 1'b0, 8'h62);
        chk("pre_rst_usedw", 32'(n_usedw), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_n_empty", 32'(n_empty), 32'h1);
        chk("arst_n_usedw", 32'(n_usedw), 32'h0);
        chk("arst_s_empty", 32'(s_empty), 32'h1);
        chk("arst_s_usedw", 32'(s_usedw), 32'h0);
        chk("arst_n_q",     32'(n_q),     32'h0);
        chk("arst_s_q",     32'(s_q),     32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h77);
        chk("post_rst_usedw", 32'(n_usedw), 32'h1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk("post_rst_q", 32'(n_q), 32'h77);

        // Randomised traffic with drifting write/read bias
        for (int i = 0; i < 600; i++) begin
            int wb;
            wb = ((i / 100) % 2 == 0) ? 70 : 35;
            step(($urandom_range(0, 99) < wb), ($urandom_range(0, 99) < (100 - wb)),
                 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/scfifo.md
SCFIFO -- requirements
Module: scfifo

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 64, data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 10, address width; depth = 2**AWIDTH words.
REQ-003 The block SHALL have parameter SHOWAHEAD, default 0; 0 = normal read, 1 = show-ahead.
REQ-004 The block SHALL have parameter ALMOST_FULL, default 2**AWIDTH-4, usedw threshold for almost_full_o.
REQ-005 The block SHALL have parameter ALMOST_EMPTY, default 4, usedw threshold for almost_empty_o.
REQ-006 The block SHALL have port clk_i, input, 1 bit, the only clock; all logic on rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-008 The block SHALL have port data_i, input, DWIDTH bits, write data.
REQ-009 The block SHALL have port wrreq_i, input, 1 bit, write request.
REQ-010 The block SHALL have port rdreq_i, input, 1 bit, read request (normal mode) or acknowledge (show-ahead mode).
REQ-011 The block SHALL have port q_o, output, DWIDTH bits, read data.
REQ-012 The block SHALL have port empty_o, output, 1 bit, no word readable.
REQ-013 The block SHALL have port full_o, output, 1 bit, usedw_o == 2**AWIDTH.
REQ-014 The block SHALL have port usedw_o, output, AWIDTH+1 bits, words held.
REQ-015 The block SHALL have port almost_full_o, output, 1 bit, usedw_o >= ALMOST_FULL.
REQ-016 The block SHALL have port almost_empty_o, output, 1 bit, usedw_o < ALMOST_EMPTY.

Function
REQ-017 A write SHALL be accepted iff wrreq_i && !full_o; a write request while full is dropped and changes no state.
REQ-018 A read SHALL be accepted iff rdreq_i && !empty_o; a read request while empty is dropped and changes no state.
REQ-019 Write and read pointers SHALL be AWIDTH bits and wrap from 2**AWIDTH-1 to 0.
REQ-020 usedw_o SHALL be registered: +1 on an accepted write only, -1 on an accepted read only, unchanged on both or neither.
REQ-021 All flags SHALL be registered and consistent with usedw_o in the same cycle.
REQ-022 When empty with wrreq_i and rdreq_i both high, the write SHALL be accepted and the read dropped.
REQ-023 When full with both high, the read SHALL be accepted and the write dropped; next cycle full_o=0, usedw_o=2**AWIDTH-1.
REQ-024 Normal mode: q_o SHALL present the word one cycle after the accepted read and hold it until the next accepted read.
REQ-025 Normal mode: empty_o SHALL deassert one cycle after the first accepted write into an empty FIFO.
REQ-026 Show-ahead mode: while !empty_o, q_o SHALL present the oldest word; an accepted read advances q_o to the next word in the following cycle, with no bubble when more words are held.
REQ-027 Show-ahead mode: empty_o SHALL deassert two cycles after the first write into an empty FIFO (one-cycle RAM prefetch); usedw_o counts the prefetched word.
REQ-028 Data order SHALL be strictly first-in first-out across pointer wrap-around.

Reset
REQ-029 While rst_i is high: pointers 0, usedw_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, q_o 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; RAM contents need not be cleared.
REQ-031 The first request after rst_i deasserts SHALL be honoured on the first rising edge.

Structure
REQ-032 A shared package scfifo_pkg SHALL hold the read-mode constants (NORMAL, SHOWAHEAD) and a usedw width function of AWIDTH.
REQ-033 Storage SHALL be a sub-module scfifo_ram: simple dual-port, one write port, one read port, one-cycle registered read, no reset.
REQ-034 Pointer, counter, flag and prefetch logic SHALL reside in scfifo.

Verification (DWIDTH=8, AWIDTH=2, ALMOST_FULL=3, ALMOST_EMPTY=1)
REQ-035 Normal mode: write 0x11,0x22,0x33,0x44 -> full_o=1, usedw_o=4, almost_full_o=1; a fifth write of 0x55 is dropped; four reads -> q_o 0x11,0x22,0x33,0x44, each one cycle after its read; then empty_o=1.
REQ-036 Wrap-around: 6 rounds of 3 writes then 3 reads of an incrementing byte -> every byte out matches its byte in; usedw_o never exceeds 3.
REQ-037 Simultaneous events: FIFO empty with wrreq_i=rdreq_i=1 and data_i 0xA5 -> usedw_o=1, no read taken; FIFO full with both high -> usedw_o=3 and the write is dropped.
REQ-038 Show-ahead mode: write 0x5A into an empty FIFO -> empty_o=0 and q_o=0x5A two cycles later; pulse rdreq_i -> empty_o=1 next cycle.
REQ-039 Reset: assert rst_i asynchronously with usedw_o=2 -> empty_o=1 and usedw_o=0 immediately; write 0x77 after release, then read -> 0x77.
